// File: rtl/avalon_pio_debounce_irq_pkg.sv
// Shared definitions for the debounced Avalon-MM PIO: register offsets and
// the debounce counter width helper.
package avalon_pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA    = 3'd0,
    ADDR_OUTSET  = 3'd1,
    ADDR_IRQMASK = 3'd2,
    ADDR_EDGECAP = 3'd3,
    ADDR_RISE_EN = 3'd4,
    ADDR_FALL_EN = 3'd5,
    ADDR_OUTCLR  = 3'd6,
    ADDR_RAW     = 3'd7
  } addr_e;

  // clog2(n+1), never less than one bit so the bypass build still has a counter
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((n >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input channel: 2-FF synchroniser, stable-count debounce filter and a
// one-cycle delayed copy of the debounced level for edge detection.
module pio_debounce_bit
  import avalon_pio_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter logic        IN_RESET   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic sync,
  output logic deb,
  output logic deb_d
);

  localparam int unsigned CW = cnt_width(DEB_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  assign sync = s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= IN_RESET;
      s2    <= IN_RESET;
      deb   <= IN_RESET;
      deb_d <= IN_RESET;
      cnt   <= '0;
    end else begin
      s1    <= in_bit;
      s2    <= s1;
      deb_d <= deb;
      if (DEB_CYCLES == 0) begin
        deb <= s2;
        cnt <= '0;
      end else if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/avalon_pio_debounce_irq.sv
// Avalon-MM PIO slave with debounced inputs, per-bit rise/fall edge capture,
// W1C edge register, atomic output set/clear and a level interrupt.
module avalon_pio_debounce_irq
  import avalon_pio_pkg::*;
#(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      DEB_CYCLES    = 4,
  parameter logic [WIDTH-1:0] IN_RESET      = '1,
  parameter logic [WIDTH-1:0] FALL_EN_RESET = '1,
  parameter logic [WIDTH-1:0] RISE_EN_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_next;
  logic             wr;
  logic             unused_wd;
  addr_e            addr;

  assign addr      = addr_e'(address);
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pio_debounce_bit #(
      .DEB_CYCLES (DEB_CYCLES),
      .IN_RESET   (IN_RESET[g])
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit  (in_port[g]),
      .sync    (sync[g]),
      .deb     (deb[g]),
      .deb_d   (deb_d[g])
    );
  end

  assign edge_det = (deb & ~deb_d & rise_en) | (~deb & deb_d & fall_en);
  assign clr_mask = (wr && addr == ADDR_EDGECAP) ? wd : '0;
  assign irq      = |(edgecap & irqmask);

  always_comb begin
    rd_next = '0;
    case (addr)
      ADDR_DATA:    rd_next[WIDTH-1:0] = deb;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      ADDR_RISE_EN: rd_next[WIDTH-1:0] = rise_en;
      ADDR_FALL_EN: rd_next[WIDTH-1:0] = fall_en;
      ADDR_RAW:     rd_next[WIDTH-1:0] = sync;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      out_port <= '0;
      irqmask  <= '0;
      edgecap  <= '0;
      rise_en  <= RISE_EN_RESET;
      fall_en  <= FALL_EN_RESET;
    end else begin
      readdata <= rd_next;
      // set after clear: an edge landing with its own W1C survives
      edgecap  <= (edgecap & ~clr_mask) | edge_det;
      if (wr) begin
        case (addr)
          ADDR_DATA:    out_port <= wd;
          ADDR_OUTSET:  out_port <= out_port | wd;
          ADDR_OUTCLR:  out_port <= out_port & ~wd;
          ADDR_IRQMASK: irqmask  <= wd;
          ADDR_RISE_EN: rise_en  <= wd;
          ADDR_FALL_EN: fall_en  <= wd;
          default:      ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avalon_pio_debounce_irq.sv
// Scoreboard bench for avalon_pio_debounce_irq with WIDTH=4, DEB_CYCLES=4.
module tb_avalon_pio_debounce_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  avalon_pio_debounce_irq #(
    .WIDTH      (4),
    .DEB_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, act, e.exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] act, input logic [31:0] exp);
    push_exp(tag, exp);
    pop_cmp(act);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    push_exp(tag, exp);
    @(posedge clk);
    #1;
    pop_cmp(readdata);
    chipselect = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // 1: reset state
    idle(3);
    expect_now("rst_readdata", readdata, 32'h0);
    expect_now("rst_out_port", 32'(out_port), 32'h0);
    expect_now("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    idle(4);
    bus_read("rst_data", 3'd0, 32'hF);
    bus_read("rst_fall_en", 3'd5, 32'hF);
    bus_read("rst_rise_en", 3'd4, 32'h0);
    bus_read("rst_irqmask", 3'd2, 32'h0);
    bus_read("rst_edgecap", 3'd3, 32'h0);

    // 2: fall on bit0, exact latency; readdata lags deb by one edge
    bus_write(3'd2, 32'h1);
    @(negedge clk);
    address    = 3'd0;
    chipselect = 1'b1;
    write_n    = 1'b1;
    in_port[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      push_exp($sformatf("lat_data_e%0d", k), (k >= 7) ? 32'hE : 32'hF);
      push_exp($sformatf("lat_irq_e%0d", k), (k >= 7) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      pop_cmp(readdata);
      pop_cmp(32'(irq));
    end
    chipselect = 1'b0;
    bus_read("fall0_edgecap", 3'd3, 32'h1);
    bus_write(3'd3, 32'h1);
    expect_now("w1c_irq", 32'(irq), 32'h0);
    bus_read("w1c_edgecap", 3'd3, 32'h0);
    in_port[0] = 1'b1;
    idle(12);
    bus_read("rise0_ignored", 3'd3, 32'h0);

    // 3: glitch rejection on bit1
    @(negedge clk);
    in_port[1] = 1'b0;
    idle(3);
    in_port[1] = 1'b1;
    idle(10);
    for (int i = 0; i < 10; i++) begin
      in_port[1] = ~in_port[1];
      idle(2);
    end
    idle(10);
    bus_read("glitch_data", 3'd0, 32'hF);
    bus_read("glitch_edgecap", 3'd3, 32'h0);
    expect_now("glitch_irq", 32'(irq), 32'h0);

    // 4: new capture on bit2 in the same cycle as its W1C
    @(negedge clk);
    in_port = 4'hA;
    idle(12);
    bus_read("cap05", 3'd3, 32'h5);
    expect_now("cap05_irq", 32'(irq), 32'h1);
    in_port = 4'hF;
    idle(12);
    bus_read("cap05_hold", 3'd3, 32'h5);
    @(negedge clk);
    in_port[2] = 1'b0;
    idle(6);
    address    = 3'd3;
    writedata  = 32'h5;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
    chipselect = 1'b0;
    bus_read("same_cycle_clr", 3'd3, 32'h4);
    bus_write(3'd3, 32'hF);
    in_port[2] = 1'b1;
    idle(12);
    bus_read("clr_all", 3'd3, 32'h0);

    // 5: output register
    bus_write(3'd0, 32'hA);
    expect_now("out_load", 32'(out_port), 32'hA);
    bus_write(3'd1, 32'h5);
    expect_now("out_set", 32'(out_port), 32'hF);
    bus_write(3'd6, 32'h3);
    expect_now("out_clr", 32'(out_port), 32'hC);
    bus_read("rd_outset", 3'd1, 32'h0);
    bus_read("rd_outclr", 3'd6, 32'h0);
    bus_read("rd_raw", 3'd7, 32'hF);
    bus_write(3'd7, 32'h0);
    expect_now("raw_wr_ignored", 32'(out_port), 32'hC);

    // 6: rise-only mode on bit3, then reset mid-debounce on bit2
    bus_write(3'd4, 32'h8);
    bus_write(3'd5, 32'h0);
    bus_read("rise_en_rb", 3'd4, 32'h8);
    @(negedge clk);
    in_port[3] = 1'b0;
    idle(12);
    bus_read("press3_nocap", 3'd3, 32'h0);
    bus_read("press3_data", 3'd0, 32'h7);
    in_port[3] = 1'b1;
    idle(12);
    bus_read("release3_cap", 3'd3, 32'h8);
    expect_now("release3_irq", 32'(irq), 32'h0);
    @(negedge clk);
    in_port[2] = 1'b0;
    idle(4);
    reset_n = 1'b0;
    idle(2);
    in_port[2] = 1'b1;
    expect_now("mid_rst_out", 32'(out_port), 32'h0);
    reset_n = 1'b1;
    idle(12);
    bus_read("post_rst_edgecap", 3'd3, 32'h0);
    bus_read("post_rst_data", 3'd0, 32'hF);
    bus_read("post_rst_fall_en", 3'd5, 32'hF);
    expect_now("post_rst_irq", 32'(irq), 32'h0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
